// File: rtl/goldschmidt_controller.sv
// goldschmidt_controller
// Sequencing FSM for the Goldschmidt divider datapath. It captures a divide
// request (N, D, IA), then steps the kSelect/ndSelect mux and the N/D register
// load enables through the initial IA scaling and ITERS refinement passes.
// It pulses done when the datapath newN register holds the quotient.
//
// Handshake: a request is accepted on a rising clk edge where start && ready.
// ready is high only in IDLE. start seen while busy is dropped, not queued.
// n_in/d_in/ia_in are sampled only at the accept edge and held on N/D/IA
// until the next accept.
//
// Optional feature: define DIV_ZERO_DETECT_EN to add the div_zero output.
// With it, an accept with d_in==0 goes directly to DONE with no enable pulses.
module goldschmidt_controller #(
  parameter int WIDTH = 16,
  parameter int ITERS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] ia_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] IA,
  output logic             kSelect,
  output logic [1:0]       ndSelect,
  output logic             nEnable,
  output logic             dEnable,
`ifdef DIV_ZERO_DETECT_EN
  output logic             div_zero,
`endif
  output logic [2:0]       state_dbg
);

  // A counter of width $clog2(ITERS+1) has zero bits when ITERS==0.
  // Keep at least one bit in that case. The counter is unused then.
  localparam int CW = (ITERS > 0) ? $clog2(ITERS + 1) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'((ITERS > 0) ? ITERS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_D = 3'd1,
    INIT_N = 3'd2,
    ITER_N = 3'd3,
    ITER_D = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   iter_cnt;
  logic            accept;

  assign accept    = (state == IDLE) && start;
  assign state_dbg = state;

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Iteration counter: cleared on accept, bumped once per completed D update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                iter_cnt <= '0;
    else if (accept)           iter_cnt <= '0;
    else if (state == ITER_D)  iter_cnt <= iter_cnt + CW'(1);
  end

  // Operand capture: held stable from one accept to the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      N  <= '0;
      D  <= '0;
      IA <= '0;
    end else if (accept) begin
      N  <= n_in;
      D  <= d_in;
      IA <= ia_in;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  // Division-by-zero flag: set or cleared at every accept and held until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      div_zero <= 1'b0;
    else if (accept) div_zero <= (d_in == '0);
  end
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_DETECT_EN
          state_next = (d_in == '0) ? DONE : INIT_D;
`else
          state_next = INIT_D;
`endif
        end
      end
      INIT_D:  state_next = INIT_N;
      INIT_N:  state_next = (ITERS > 0) ? ITER_N : DONE;
      ITER_N:  state_next = ITER_D;
      ITER_D:  state_next = (iter_cnt == LAST_ITER) ? DONE : ITER_N;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode: datapath controls depend only on the registered state.
  // N is updated before D in each iteration, so both updates use the same K.
  always_comb begin
    ready    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    kSelect  = 1'b0;
    ndSelect = 2'b00;
    nEnable  = 1'b0;
    dEnable  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      INIT_D: begin
        ndSelect = 2'b00;
        dEnable  = 1'b1;
      end
      INIT_N: begin
        ndSelect = 2'b01;
        nEnable  = 1'b1;
      end
      ITER_N: begin
        kSelect  = 1'b1;
        ndSelect = 2'b11;
        nEnable  = 1'b1;
      end
      ITER_D: begin
        kSelect  = 1'b1;
        ndSelect = 2'b10;
        dEnable  = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule
